// File: rtl/adc082s021_spi_reader.sv
// Free-running SPI master and command/data formatter for a TI ADC082S021.
// Repeats NBITS-bit frames forever: shifts the channel-select command out on mosi
// and shifts the conversion result in from miso. Between frames it shows the low
// 12 received bits on data and holds ready high.
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset    synchronous, active-high reset
//   channel  ADC input address, placed in command bits [13:11], latched at frame start
//   miso     ADC DOUT
//   sclk     SPI clock, idle low
//   ss       active-high frame-active indicator
//   cs_n     ADC chip select, active low (~ss)
//   mosi     ADC DIN, changes only on the edge that raises sclk
//   data     last completed frame's received bits [11:0]
//   ready    high between frames while data holds a fresh result
module adc082s021_spi_reader #(
  parameter int unsigned BYTES   = 2,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  channel,
  input  logic        miso,
  output logic        sclk,
  output logic        ss,
  output logic        cs_n,
  output logic        mosi,
  output logic [11:0] data,
  output logic        ready
);

  localparam int unsigned NBITS = 8 * BYTES;
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned BitW  = $clog2(NBITS + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP - 1);
  localparam logic [BitW-1:0] BitsAll = BitW'(NBITS);

  typedef enum logic [0:0] {StGap, StXfer} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] cmd_q, cmd_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;
  logic [11:0]      data_q, data_d;
  logic             ready_q, ready_d;

  logic [15:0]      cmd_word;

  // Command word: bits 13:11 carry the channel, everything else is zero.
  assign cmd_word = {2'b00, channel, 11'b0};

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    data_d    = data_q;
    ready_d   = ready_q;

    unique case (state_q)
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d   = StXfer;
          ss_d      = 1'b1;
          ready_d   = 1'b0;
          sclk_d    = 1'b0;
          cmd_d     = NBITS'(cmd_word);
          bit_cnt_d = '0;
          // Preloading the divider makes the first sclk rise one clk after ss rises.
          div_cnt_d = DivLast;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StXfer: begin
        if (div_cnt_q != DivLast) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: sample the bit the slave presented after the rise.
            sclk_d = 1'b0;
            rx_d   = {rx_q[NBITS-2:0], miso};
          end else if (bit_cnt_q == BitsAll) begin
            // Last low half-period done: close the frame and publish the result.
            state_d   = StGap;
            ss_d      = 1'b0;
            mosi_d    = 1'b0;
            data_d    = rx_q[11:0];
            ready_d   = 1'b1;
            gap_cnt_d = GapLast;
          end else begin
            sclk_d    = 1'b1;
            mosi_d    = cmd_q[NBITS-1];
            cmd_d     = {cmd_q[NBITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StGap;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b0;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
    end
  end

  assign sclk  = sclk_q;
  assign ss    = ss_q;
  assign cs_n  = ~ss_q;
  assign mosi  = mosi_q;
  assign data  = data_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_adc082s021_spi_reader.sv
// Bench for adc082s021_spi_reader: an ADC slave model drives miso, a monitor
// captures mosi on falling sclk and counts edges, and directed frames are checked
// from a vector table plus hand-written reset and channel-change sequences.
module tb_adc082s021_spi_reader;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  channel;
  logic        miso;
  logic        sclk, ss, cs_n, mosi, ready;
  logic [11:0] data;

  adc082s021_spi_reader #(
    .BYTES  (2),
    .CLK_DIV(CLK_DIV),
    .GAP    (GAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .channel(channel),
    .miso   (miso),
    .sclk   (sclk),
    .ss     (ss),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .data   (data),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor / slave state.
  logic [15:0] next_word = 16'h0;
  logic [15:0] slv       = 16'h0;
  logic [15:0] mosi_cap  = 16'h0;
  logic [15:0] last_mosi = 16'h0;
  int rise_cnt = 0, fall_cnt = 0, last_rise = 0, last_fall = 0;
  int since_rise = 0, gap_len = 0;
  int cs_err = 0, per_err = 0, gap_err = 0, edge_err = 0;
  bit skip_gap = 1'b1;
  logic ss_prev = 1'b0, sclk_prev = 1'b0;

  initial miso = 1'b0;

  always @(negedge clk) begin
    if (cs_n !== ~ss) cs_err++;
    since_rise++;
    if (ss === 1'b1 && ss_prev === 1'b0) begin
      if (sclk !== 1'b0) edge_err++;
      if (!skip_gap && gap_len != GAP) gap_err++;
      rise_cnt = 0;
      fall_cnt = 0;
      mosi_cap = 16'h0;
      slv      = next_word;
    end
    if (ss === 1'b0 && ss_prev === 1'b1) begin
      if (sclk !== 1'b0) edge_err++;
      last_rise = rise_cnt;
      last_fall = fall_cnt;
      last_mosi = mosi_cap;
      gap_len   = 1;
    end else if (ss === 1'b0) begin
      gap_len++;
    end
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rise_cnt++;
      if (rise_cnt > 1 && since_rise != 2 * CLK_DIV) per_err++;
      since_rise = 0;
      // Slave presents frame bit 16-n after rising edge n.
      if (rise_cnt <= 16) miso = slv[16 - rise_cnt];
    end
    if (sclk === 1'b0 && sclk_prev === 1'b1) begin
      fall_cnt++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    ss_prev   = ss;
    sclk_prev = sclk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ss(input logic lvl, input int budget, input string nm);
    int n = 0;
    while (ss !== lvl && n < budget) begin
      step();
      n++;
    end
    total++;
    if (ss !== lvl) begin
      bad++;
      $display("FAIL %s: ss timeout got %b expected %b", nm, ss, lvl);
    end
  endtask

  task automatic check_frame(input string nm, input logic [15:0] exp_mosi,
                             input logic [11:0] exp_data);
    check({nm, "_rise"}, 32'(last_rise), 32'd16);
    check({nm, "_fall"}, 32'(last_fall), 32'd16);
    check({nm, "_mosi"}, 32'(last_mosi), 32'(exp_mosi));
    check({nm, "_ready"}, 32'(ready), 32'd1);
    check({nm, "_data"}, 32'(data), 32'(exp_data));
  endtask

  typedef struct {
    logic [2:0]  chan;
    logic [15:0] word;
    logic [15:0] exp_mosi;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{chan: 3'd1, word: 16'h0ff0, exp_mosi: 16'h0800, exp_data: 12'hff0};
    vecs[1] = '{chan: 3'd1, word: 16'h0120, exp_mosi: 16'h0800, exp_data: 12'h120};
    vecs[2] = '{chan: 3'd0, word: 16'hFABC, exp_mosi: 16'h0000, exp_data: 12'hABC};
    vecs[3] = '{chan: 3'd5, word: 16'h0A5F, exp_mosi: 16'h2800, exp_data: 12'hA5F};
    vecs[4] = '{chan: 3'd7, word: 16'h0001, exp_mosi: 16'h3800, exp_data: 12'h001};

    reset     = 1'b1;
    channel   = vecs[0].chan;
    next_word = vecs[0].word;
    repeat (3) step();
    check("rst_ss", 32'(ss), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      channel   = vecs[i].chan;
      next_word = vecs[i].word;
      wait_ss(1'b1, 20, $sformatf("v%0d_start", i));
      check($sformatf("v%0d_ready_drop", i), 32'(ready), 32'd0);
      skip_gap = 1'b0;
      wait_ss(1'b0, 200, $sformatf("v%0d_end", i));
      check_frame($sformatf("v%0d", i), vecs[i].exp_mosi, vecs[i].exp_data);
    end

    // Channel change mid-frame only affects the following frame; ready and data
    // hold through the gap.
    channel   = 3'd0;
    next_word = 16'h0333;
    wait_ss(1'b1, 20, "chg_start");
    repeat (10) step();
    channel   = 3'd5;
    next_word = 16'h0444;
    wait_ss(1'b0, 200, "chg_end0");
    check_frame("chg0", 16'h0000, 12'h333);
    for (int k = 0; k < int'(GAP) - 1; k++) begin
      step();
      check($sformatf("gap_ready%0d", k), 32'(ready), 32'd1);
      check($sformatf("gap_data%0d", k), 32'(data), 32'h333);
    end
    wait_ss(1'b1, 20, "chg_start1");
    wait_ss(1'b0, 200, "chg_end1");
    check_frame("chg1", 16'h2800, 12'h444);

    // Reset in the middle of a frame aborts it on the next clock.
    wait_ss(1'b1, 20, "abort_start");
    repeat (20) step();
    reset = 1'b1;
    skip_gap = 1'b1;
    step();
    check("abort_ss", 32'(ss), 32'd0);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    channel   = 3'd2;
    next_word = 16'h0F5A;
    reset     = 1'b0;
    wait_ss(1'b1, 20, "post_start");
    skip_gap = 1'b0;
    wait_ss(1'b0, 200, "post_end");
    check_frame("post", 16'h1000, 12'hF5A);

    check("cs_n_vs_ss", 32'(cs_err), 32'd0);
    check("sclk_period", 32'(per_err), 32'd0);
    check("gap_length", 32'(gap_err), 32'd0);
    check("sclk_at_ss_edge", 32'(edge_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
